// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, WB same-cycle bypass and a stall counter.
// One cycle from ID to EX. A load-use hazard or hold drops pc_write/if_id_write in the same cycle.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [DW-1:0]    id_a,
  input  logic [DW-1:0]    id_b,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_reg_w,
  input  logic             id_mem_r,
  input  logic             id_mem_w,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic [3:0]       id_alu_op,
  input  logic             wb_reg_w,
  input  logic [4:0]       wb_addr,
  input  logic [DW-1:0]    wb_data,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_wr_addr,
  output logic [DW-1:0]    ex_a,
  output logic [DW-1:0]    ex_b,
  output logic [DW-1:0]    ex_imm,
  output logic             ex_reg_w,
  output logic             ex_mem_r,
  output logic             ex_mem_w,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic [3:0]       ex_alu_op,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    wr_addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic          reg_w;
    logic          mem_r;
    logic          mem_w;
    logic          mem_to_reg;
    logic          alu_src;
    logic [3:0]    alu_op;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  logic lu;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = id_use_rs && (ex_q.wr_addr == id_rs);
    rt_hit = id_use_rt && (ex_q.wr_addr == id_rt);
    lu     = ex_q.valid && ex_q.mem_r && (ex_q.wr_addr != 5'd0) && (rs_hit || rt_hit);
  end

  assign pc_write    = ~(lu | hold);
  assign if_id_write = ~(lu | hold);

  // Register file writes at the end of WB, so a same-cycle read must see wb_data instead.
  always_comb begin
    ex_d            = '0;
    ex_d.valid      = 1'b1;
    ex_d.rs         = id_rs;
    ex_d.rt         = id_rt;
    ex_d.wr_addr    = id_reg_dst ? id_rd : id_rt;
    ex_d.a          = (wb_reg_w && (wb_addr != 5'd0) && (wb_addr == id_rs)) ? wb_data : id_a;
    ex_d.b          = (wb_reg_w && (wb_addr != 5'd0) && (wb_addr == id_rt)) ? wb_data : id_b;
    ex_d.imm        = id_imm;
    ex_d.reg_w      = id_reg_w;
    ex_d.mem_r      = id_mem_r;
    ex_d.mem_w      = id_mem_w;
    ex_d.mem_to_reg = id_mem_to_reg;
    ex_d.alu_src    = id_alu_src;
    ex_d.alu_op     = id_alu_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      if (flush || lu) ex_q <= '0;
      else             ex_q <= ex_d;
      // A flush already redirects fetch, so a coincident hazard is not counted as a stall.
      if (lu && !flush && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_wr_addr    = ex_q.wr_addr;
  assign ex_a          = ex_q.a;
  assign ex_b          = ex_q.b;
  assign ex_imm        = ex_q.imm;
  assign ex_reg_w      = ex_q.reg_w;
  assign ex_mem_r      = ex_q.mem_r;
  assign ex_mem_w      = ex_q.mem_w;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a cycle-level reference model and literal spot checks.
module tb_id_ex_stage;
  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst, hold, flush;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_use_rs, id_use_rt;
  logic [DW-1:0]    id_a, id_b, id_imm;
  logic             id_reg_w, id_mem_r, id_mem_w, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]       id_alu_op;
  logic             wb_reg_w;
  logic [4:0]       wb_addr;
  logic [DW-1:0]    wb_data;
  logic             ex_valid;
  logic [4:0]       ex_rs, ex_rt, ex_wr_addr;
  logic [DW-1:0]    ex_a, ex_b, ex_imm;
  logic             ex_reg_w, ex_mem_r, ex_mem_w, ex_mem_to_reg, ex_alu_src;
  logic [3:0]       ex_alu_op;
  logic             pc_write, if_id_write;
  logic [CNT_W-1:0] stall_cnt;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_reg_w(id_reg_w), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op),
    .wb_reg_w(wb_reg_w), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the EX slot as an instruction record, plus a plain integer counter.
  bit        m_known = 0;
  bit        m_valid;
  int        m_rs, m_rt, m_wr, m_op, m_cnt;
  bit [31:0] m_a, m_b, m_imm;
  bit        m_reg_w, m_mem_r, m_mem_w, m_m2r, m_asrc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rs = 0; m_rt = 0; m_wr = 0; m_op = 0;
    m_a = 0; m_b = 0; m_imm = 0;
    m_reg_w = 0; m_mem_r = 0; m_mem_w = 0; m_m2r = 0; m_asrc = 0;
  endtask

  function automatic bit model_lu();
    bit dep;
    dep = (id_use_rs && m_wr == int'(id_rs)) || (id_use_rt && m_wr == int'(id_rt));
    return m_valid && m_mem_r && m_wr != 0 && dep;
  endfunction

  // One clock: check zero-latency outputs, advance the model, then check registered outputs.
  task automatic cycle();
    bit lu;
    #1;
    lu = model_lu();
    if (m_known && !rst) begin
      chk("pc_write", pc_write, !(lu || hold));
      chk("if_id_write", if_id_write, !(lu || hold));
    end
    if (rst) begin
      model_bubble(); m_cnt = 0; m_known = 1;
    end else if (!hold) begin
      if (lu && !flush) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (flush || lu) model_bubble();
      else begin
        m_valid = 1; m_rs = id_rs; m_rt = id_rt;
        m_wr    = id_reg_dst ? int'(id_rd) : int'(id_rt);
        m_a     = (wb_reg_w && wb_addr != 0 && wb_addr == id_rs) ? wb_data : id_a;
        m_b     = (wb_reg_w && wb_addr != 0 && wb_addr == id_rt) ? wb_data : id_b;
        m_imm   = id_imm; m_op = id_alu_op;
        m_reg_w = id_reg_w; m_mem_r = id_mem_r; m_mem_w = id_mem_w;
        m_m2r   = id_mem_to_reg; m_asrc = id_alu_src;
      end
    end
    @(posedge clk); #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_rs", ex_rs, m_rs);
    chk("ex_rt", ex_rt, m_rt);
    chk("ex_wr_addr", ex_wr_addr, m_wr);
    chk("ex_a", ex_a, m_a);
    chk("ex_b", ex_b, m_b);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_ctl", {ex_reg_w, ex_mem_r, ex_mem_w, ex_mem_to_reg, ex_alu_src},
        {m_reg_w, m_mem_r, m_mem_w, m_m2r, m_asrc});
    chk("ex_alu_op", ex_alu_op, m_op);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic nop();
    id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_a = 0; id_b = 0; id_imm = 0;
    id_reg_w = 0; id_mem_r = 0; id_mem_w = 0; id_mem_to_reg = 0;
    id_alu_src = 0; id_reg_dst = 0; id_alu_op = 0;
  endtask

  task automatic ld(input int rt, input int rs);
    nop();
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = 1; id_a = 32'h100; id_imm = 32'h4;
    id_reg_w = 1; id_mem_r = 1; id_mem_to_reg = 1; id_alu_src = 1; id_alu_op = 4'd2;
  endtask

  task automatic add(input int rd, input int rs, input int rt);
    nop();
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd); id_use_rs = 1; id_use_rt = 1;
    id_a = 32'h11; id_b = 32'h22; id_reg_w = 1; id_reg_dst = 1; id_alu_op = 4'd2;
  endtask

  int saved;

  initial begin
    rst = 1; hold = 0; flush = 0;
    wb_reg_w = 0; wb_addr = 0; wb_data = 0;
    // Reset with arbitrary inputs on the ID side.
    for (int i = 0; i < 2; i++) begin
      add($urandom_range(31), $urandom_range(31), $urandom_range(31));
      id_mem_r = 1'($urandom); id_a = $urandom; id_imm = $urandom;
      cycle();
    end
    rst = 0; nop(); #1;
    chk("lit_rst_valid", ex_valid, 0);
    chk("lit_rst_cnt", stall_cnt, 0);
    chk("lit_rst_pc_write", pc_write, 1);
    cycle();

    // Load-use on Rs.
    ld(8, 1); cycle();
    add(9, 8, 2); #1;
    chk("lit_lu_pc_write", pc_write, 0);
    chk("lit_lu_if_id_write", if_id_write, 0);
    cycle();
    chk("lit_bubble_valid", ex_valid, 0);
    chk("lit_bubble_cnt", stall_cnt, 1);
    cycle();
    chk("lit_add_in_ex", {ex_valid, ex_rs, ex_wr_addr}, {1'b1, 5'd8, 5'd9});

    // No false stalls: load to $0, and an unused rt matching the load target.
    ld(0, 1); cycle();
    add(3, 0, 0); #1;
    chk("lit_r0_pc_write", pc_write, 1);
    cycle();
    ld(8, 1); cycle();
    add(3, 3, 8); id_use_rt = 0; #1;
    chk("lit_nouse_pc_write", pc_write, 1);
    cycle();
    chk("lit_nostall_cnt", stall_cnt, 1);

    // WB bypass on Rs and Rt, then suppressed for $0.
    add(4, 5, 6); id_a = 32'h1111; id_b = 32'h2222;
    wb_reg_w = 1; wb_addr = 5; wb_data = 32'hABCD;
    cycle();
    chk("lit_bypass_a", ex_a, 32'hABCD);
    wb_addr = 6; cycle();
    chk("lit_bypass_b", {ex_a, ex_b}, {32'h1111, 32'hABCD});
    wb_addr = 0; cycle();
    chk("lit_bypass_r0", ex_a, 32'h1111);
    wb_reg_w = 0; wb_addr = 0;

    // Flush coinciding with load-use.
    ld(8, 1); cycle();
    saved = m_cnt;
    add(9, 8, 2); flush = 1; cycle();
    flush = 0;
    chk("lit_flush_lu_valid", ex_valid, 0);
    chk("lit_flush_lu_cnt", stall_cnt, saved);
    cycle();

    // Hold for 3 cycles during a pending stall.
    ld(8, 1); cycle();
    add(9, 8, 2); hold = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("lit_hold_frozen", {ex_valid, ex_mem_r, ex_wr_addr}, {1'b1, 1'b1, 5'd8});
    chk("lit_hold_cnt", stall_cnt, saved);
    hold = 0; cycle();
    chk("lit_release_bubble", {ex_valid, stall_cnt}, {1'b0, 4'(saved + 1)});
    cycle();
    chk("lit_release_enter", {ex_valid, ex_rs}, {1'b1, 5'd8});

    // Reset in the middle of a stall.
    ld(8, 1); cycle();
    add(9, 8, 2); rst = 1; cycle();
    rst = 0; #1;
    chk("lit_mid_rst_pc_write", pc_write, 1);
    cycle();

    // Saturation: 20 stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      ld(8, 1); cycle();
      add(9, 8, 2); cycle();
      cycle();
    end
    chk("lit_sat_cnt", stall_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
